// File: rtl/aes_dec_word_adapter.sv
// aes_dec_word_adapter: 32-bit word stream to 128-bit block adapter around a combinational AES inverse cipher.
// Collects key and ciphertext words, gives the core CORE_LAT cycles to settle, then unloads plaintext words.
module aes_dec_word_adapter #(
  parameter int CORE_LAT = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [31:0]  in_data,
  input  logic         in_is_key,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [0:127] ct_out,
  output logic [0:127] key_out,
  output logic         core_start,
  input  logic [0:127] pt_in,
  output logic [31:0]  out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         out_last,
  output logic         key_loaded,
  output logic         err
);
  typedef enum logic [1:0] {LOAD, WAIT, UNLOAD} state_t;
  state_t       state_q, state_d;
  logic [1:0]   key_cnt_q, key_cnt_d;
  logic [1:0]   ct_cnt_q, ct_cnt_d;
  logic [1:0]   out_cnt_q, out_cnt_d;
  logic [3:0]   settle_q, settle_d;
  logic [0:127] ct_q, ct_d;
  logic [0:127] key_q, key_d;
  logic [0:127] pt_q, pt_d;
  logic         key_loaded_q, key_loaded_d;
  logic         core_start_q, core_start_d;
  logic         err_q, err_d;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= LOAD;
      key_cnt_q    <= '0;
      ct_cnt_q     <= '0;
      out_cnt_q    <= '0;
      settle_q     <= '0;
      ct_q         <= '0;
      key_q        <= '0;
      pt_q         <= '0;
      key_loaded_q <= 1'b0;
      core_start_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      key_cnt_q    <= key_cnt_d;
      ct_cnt_q     <= ct_cnt_d;
      out_cnt_q    <= out_cnt_d;
      settle_q     <= settle_d;
      ct_q         <= ct_d;
      key_q        <= key_d;
      pt_q         <= pt_d;
      key_loaded_q <= key_loaded_d;
      core_start_q <= core_start_d;
      err_q        <= err_d;
    end
  end
  // Key words are refused while a ciphertext block is partly loaded so the key never changes mid-block.
  always_comb begin
    state_d      = state_q;
    key_cnt_d    = key_cnt_q;
    ct_cnt_d     = ct_cnt_q;
    out_cnt_d    = out_cnt_q;
    settle_d     = settle_q;
    ct_d         = ct_q;
    key_d        = key_q;
    pt_d         = pt_q;
    key_loaded_d = key_loaded_q;
    core_start_d = 1'b0;
    err_d        = 1'b0;
    if (state_q == LOAD && in_valid) begin
      if (in_is_key) begin
        if (ct_cnt_q != 2'd0) begin
          err_d = 1'b1;
        end else begin
          key_d[{key_cnt_q, 5'd0} +: 32] = in_data;
          key_cnt_d    = key_cnt_q + 2'd1;
          key_loaded_d = key_cnt_q == 2'd3;
        end
      end else if (!key_loaded_q) begin
        err_d = 1'b1;
      end else begin
        ct_d[{ct_cnt_q, 5'd0} +: 32] = in_data;
        ct_cnt_d = ct_cnt_q + 2'd1;
        if (ct_cnt_q == 2'd3) begin
          state_d      = WAIT;
          settle_d     = 4'(CORE_LAT);
          core_start_d = 1'b1;
        end
      end
    end else if (state_q == WAIT) begin
      settle_d = settle_q - 4'd1;
      if (settle_q == 4'd1) begin
        pt_d    = pt_in;
        state_d = UNLOAD;
      end
    end else if (state_q == UNLOAD && out_ready) begin
      out_cnt_d = out_cnt_q + 2'd1;
      state_d   = out_cnt_q == 2'd3 ? LOAD : UNLOAD;
    end
  end
  assign in_ready   = state_q == LOAD;
  assign out_valid  = state_q == UNLOAD;
  assign out_last   = out_valid && out_cnt_q == 2'd3;
  assign out_data   = out_valid ? pt_q[{out_cnt_q, 5'd0} +: 32] : 32'd0;
  assign ct_out     = ct_q;
  assign key_out    = key_q;
  assign core_start = core_start_q;
  assign key_loaded = key_loaded_q;
  assign err        = err_q;
endmodule
